osd_ram_reader: RTL and testbench
=================================

Name: osd_ram_reader

Overview:
- Read-side engine for the 2048x8 dual-clock OSD buffer RAM. It runs entirely in the RAM read clock domain.
- On a start request it fetches a run of bytes from a base address. It assumes a fixed registered read latency and streams the bytes out on a valid/ready interface with m_last.
- It absorbs downstream backpressure with a small show-ahead FIFO and credit-limited read issue.
- It feeds the OSD overlay/pixel path.

Parameters:
- ADDR_WIDTH, 11: RAM address width; the RAM depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8: RAM and stream data width.
- RD_LATENCY, 2: cycles from ram_rd_en/ram_rd_addr to valid ram_rd_data (RAM output register enabled).
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of 2 and >= RD_LATENCY+1.

Ports:
- rd_clk, in, 1: read clock; all logic is on the rising edge.
- rd_rst, in, 1: reset. Synchronous to rd_clk, active-high.
- start, in, 1: one-cycle request. Sampled only in IDLE.
- start_addr, in, ADDR_WIDTH: first RAM address.
- start_len, in, ADDR_WIDTH+1: byte count, 0..2**ADDR_WIDTH.
- busy, out, 1: high from the accepted start until done.
- done, out, 1: one-cycle pulse when a run completes.
- ram_rd_en, out, 1: read strobe to the RAM.
- ram_rd_addr, out, ADDR_WIDTH: RAM read address.
- ram_rd_data, in, DATA_WIDTH: RAM read data, RD_LATENCY cycles after ram_rd_en.
- m_data, out, DATA_WIDTH: stream data.
- m_valid, out, 1: stream valid.
- m_ready, in, 1: stream ready.
- m_last, out, 1: marks the final byte of a run.

Behaviour:
- **Reset:** when rd_rst is high at a clock edge, the following are cleared, with absolute priority over all other activity:
  - outputs busy, done, ram_rd_en, m_valid, m_last = 0; ram_rd_addr = 0; m_data = 0.
  - FIFO emptied, in-flight pipe cleared, state = IDLE.
  - Reset mid-run discards all outstanding and buffered data with no done pulse. The first start after reset behaves normally.
- **States:** IDLE, READ, DRAIN.
- **IDLE:**
  - start=1 with start_len>0: latch addr/len, reset the issue and accept counters, busy=1, go to READ.
  - start=1 with start_len=0: done=1 on the next cycle, busy stays 0, no reads issued, no beats emitted.
- **READ:**
  - Issue rule: ram_rd_en=1 in a cycle only if issued < len AND (inflight + fifo_count) < FIFO_DEPTH. Credits count the read issued this cycle.
  - ram_rd_addr increments by 1 per issued read and wraps from 2**ADDR_WIDTH-1 to 0.
  - When the last read is issued, go to DRAIN.
- **In-flight tracking:** an RD_LATENCY-deep valid shift register. When its tail is 1, ram_rd_data is written into the FIFO.
  - The credit rule guarantees the FIFO never overflows. An assertion fires if a write is attempted while the FIFO is full.
- **Output FIFO:** show-ahead.
  - m_valid = FIFO not empty; m_data = head entry.
  - m_data and m_last stay stable while m_valid && !m_ready.
  - A beat transfers when m_valid && m_ready.
  - A simultaneous FIFO write and read is permitted in the same cycle, including when the FIFO is full at that cycle.
- **m_last:** high on the beat whose accept count equals len.
- **DRAIN:** wait for the final beat to transfer, then go to IDLE with busy=0 and done=1 in the following cycle.
- **Busy handling:** start is ignored while busy, and no state changes.
- **Latency and throughput:**
  - Start sampled at cycle 0; first ram_rd_en at cycle 1; first m_valid at cycle 1+RD_LATENCY+1 (cycle 4 at defaults).
  - Sustained throughput with m_ready=1 is 1 byte/cycle.
- **len = 2**ADDR_WIDTH:** reads the whole RAM exactly once, ending at start_addr-1 modulo 2**ADDR_WIDTH.

Test Plan:
RAM model: RD_LATENCY=2, preloaded mem[a] = 255 - (a mod 256).
1. start_addr=0, start_len=16, m_ready=1 -> m_data 255,254,...,240 on 16 consecutive cycles. First m_valid at cycle 4. m_last only on 240. done pulses one cycle after the 240 beat; busy falls at the same time.
2. start_addr=2046, start_len=4 -> ram_rd_addr sequence 2046,2047,0,1 -> m_data 1,0,255,254 with m_last on 254.
3. start_addr=100, start_len=64, m_ready low for cycles 5-14 then toggling every cycle -> never more than 4 reads outstanding plus buffered. m_data is held stable while stalled. All 64 bytes arrive in order, 155 down to 92, with no duplicates.
4. start_len=0 -> done pulse on the next cycle. ram_rd_en, m_valid and busy never assert.
5. start asserted again mid-run with different addr/len -> ignored, and the original run completes unchanged. Separately, rd_rst asserted at beat 5 of a 32-byte run -> next cycle m_valid=0, busy=0, no done pulse. A new start_addr=0, start_len=2 then yields 255,254.
6. start_addr=512, start_len=2048, m_ready=1 -> 2048 beats. The last address read is 511, last data 0, and m_last is high only on the final beat.

Source files
------------

// File: rtl/osd_ram_reader.sv
// Read-side engine for the OSD buffer RAM. It fetches a run of bytes from a base address
// and streams them out through a show-ahead FIFO, issuing reads only while FIFO credit remains.
module osd_ram_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_rd_clk,
  input  logic                  i_rd_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH:0]   i_start_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_m_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_issued;
  logic [LEN_W-1:0]      r_accepted;
  logic                  r_busy;
  logic                  r_done;
  logic [RD_LATENCY-1:0] r_pipe;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [CNT_W:0]        w_credits;
  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_fifo_wr;
  logic                  w_fifo_rd;

  // Credits cover both reads still in the RAM pipeline and bytes already buffered.
  always_comb begin
    w_credits = {1'b0, r_count};
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_credits = w_credits + {{CNT_W{1'b0}}, r_pipe[i]};
    end
  end

  assign w_issue      = (r_state == S_READ) && (r_issued < r_len) && (w_credits < DEPTH_C);
  assign w_last_issue = w_issue && (r_issued == r_len - LEN_W'(1));
  assign w_fifo_wr    = r_pipe[RD_LATENCY-1];
  assign w_fifo_rd    = o_m_valid && i_m_ready;

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_ram_rd_en   = w_issue;
  assign o_ram_rd_addr = r_addr;
  assign o_m_valid     = (r_count != '0);
  assign o_m_data      = o_m_valid ? r_mem[r_rd_ptr] : '0;
  assign o_m_last      = o_m_valid && (r_accepted == r_len - LEN_W'(1));

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_issue) begin
        r_addr   <= r_addr + ADDR_WIDTH'(1);
        r_issued <= r_issued + LEN_W'(1);
      end
      if (w_fifo_rd) begin
        r_accepted <= r_accepted + LEN_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_start_len != '0) begin
              r_addr     <= i_start_addr;
              r_len      <= i_start_len;
              r_issued   <= '0;
              r_accepted <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_READ;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (w_last_issue) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_fifo_rd && o_m_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Storage carries no reset; emptiness is tracked by the count and pointers alone.
  always_ff @(posedge i_rd_clk) begin
    if (w_fifo_wr) begin
      r_mem[r_wr_ptr] <= i_ram_rd_data;
    end
  end

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_fifo_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_fifo_wr, w_fifo_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_fifo_no_overflow: assert property (@(posedge i_rd_clk) disable iff (i_rd_rst)
    !(w_fifo_wr && !w_fifo_rd && (r_count == DEPTH_C[CNT_W-1:0])));

endmodule

// File: tb/tb_osd_ram_reader.sv
// Directed bench for osd_ram_reader against a two-stage registered RAM model
// preloaded with mem[a] = 255 - (a mod 256).
module tb_osd_ram_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [10:0] startAddr;
  logic [11:0] startLen;
  logic        busy;
  logic        done;
  logic        ramRdEn;
  logic [10:0] ramRdAddr;
  logic [7:0]  ramRdData;
  logic [7:0]  mData;
  logic        mValid;
  logic        mReady;
  logic        mLast;

  int checks = 0;
  int errors = 0;

  int beatData[$];
  int beatLast[$];
  int beatCycle[$];
  int rdAddrs[$];
  int firstValid, doneCycle, doneCount, busyFall, maxOut, stallBad;
  int issuedCnt, acceptedCnt;
  bit busySeen, timedOut, prevStall, prevLast;
  logic [7:0] prevData;

  logic [7:0] ramS1, ramS2;

  osd_ram_reader #(
    .ADDR_WIDTH(11),
    .DATA_WIDTH(8),
    .RD_LATENCY(2),
    .FIFO_DEPTH(4)
  ) dut (
    .i_rd_clk     (clk),
    .i_rd_rst     (rst),
    .i_start      (start),
    .i_start_addr (startAddr),
    .i_start_len  (startLen),
    .o_busy       (busy),
    .o_done       (done),
    .o_ram_rd_en  (ramRdEn),
    .o_ram_rd_addr(ramRdAddr),
    .i_ram_rd_data(ramRdData),
    .o_m_data     (mData),
    .o_m_valid    (mValid),
    .i_m_ready    (mReady),
    .o_m_last     (mLast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramRdEn) ramS1 <= 8'd255 - ramRdAddr[7:0];
    ramS2 <= ramS1;
  end
  assign ramRdData = ramS2;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Records one cycle of activity; a beat is logged when it will transfer on the next edge.
  task automatic observe(input int c);
    if (ramRdEn) begin
      rdAddrs.push_back(int'(ramRdAddr));
      issuedCnt++;
    end
    if (issuedCnt - acceptedCnt > maxOut) maxOut = issuedCnt - acceptedCnt;
    if (mValid && firstValid < 0) firstValid = c;
    if (prevStall && (!mValid || mData !== prevData || mLast !== prevLast)) stallBad++;
    prevStall = mValid && !mReady;
    prevData  = mData;
    prevLast  = mLast;
    if (mValid && mReady) begin
      beatData.push_back(int'(mData));
      beatLast.push_back(int'(mLast));
      beatCycle.push_back(c);
      acceptedCnt++;
    end
    if (busy) busySeen = 1;
    else if (busySeen && busyFall < 0) busyFall = c;
    if (done) begin
      doneCount++;
      if (doneCycle < 0) doneCycle = c;
    end
  endtask

  // mode 0: ready always high; 1: stall cycles 5-14 then toggle; 2: second start at cycle 3
  task automatic doRun(input logic [10:0] addr, input logic [11:0] len, input int mode,
                       input int maxCycles);
    beatData.delete(); beatLast.delete(); beatCycle.delete(); rdAddrs.delete();
    firstValid = -1; doneCycle = -1; doneCount = 0; busyFall = -1; maxOut = 0; stallBad = 0;
    issuedCnt = 0; acceptedCnt = 0; busySeen = 0; timedOut = 0; prevStall = 0; prevLast = 0;
    prevData = 8'd0;
    start = 1'b1; startAddr = addr; startLen = len; mReady = 1'b1;
    observe(0);
    stepCycle();
    for (int c = 1; c <= maxCycles; c++) begin
      if (mode == 2 && c == 3) begin
        start = 1'b1; startAddr = 11'd0; startLen = 12'd20;
      end else begin
        start = 1'b0;
      end
      if (mode == 1 && c >= 5) mReady = (c <= 14) ? 1'b0 : (c % 2 == 1);
      else mReady = 1'b1;
      observe(c);
      if (doneCycle >= 0) break;
      stepCycle();
    end
    if (doneCycle < 0) timedOut = 1;
    start = 1'b0; mReady = 1'b1;
    repeat (4) begin
      stepCycle();
      observe(-1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) stepCycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (ramRdEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en got %b want 0", ramRdEn); end
    checks++; if (ramRdAddr !== 11'd0) begin errors++; $display("[TB] FAIL reset_rd_addr got %0d want 0", ramRdAddr); end
    checks++; if (mValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got %b want 0", mValid); end
    checks++; if (mLast !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_last got %b want 0", mLast); end
    checks++; if (mData !== 8'd0) begin errors++; $display("[TB] FAIL reset_m_data got %0d want 0", mData); end
    rst = 1'b0;
    stepCycle();
  endtask

  task automatic test_basic();
    int bad = 0;
    doRun(11'd0, 12'd16, 0, 100);
    checks++; if (timedOut) begin errors++; $display("[TB] FAIL basic_timeout got done=none want done"); end
    checks++; if (beatData.size() != 16) begin errors++; $display("[TB] FAIL basic_count got %0d want 16", beatData.size()); end
    for (int i = 0; i < beatData.size(); i++) begin
      if (beatData[i] != 255 - i || beatCycle[i] != 4 + i || beatLast[i] != int'(i == 15)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL basic_beats got %0d bad beats want 0", bad); end
    checks++; if (firstValid != 4) begin errors++; $display("[TB] FAIL basic_first_valid got %0d want 4", firstValid); end
    checks++; if (doneCycle != 20) begin errors++; $display("[TB] FAIL basic_done_cycle got %0d want 20", doneCycle); end
    checks++; if (busyFall != 20) begin errors++; $display("[TB] FAIL basic_busy_fall got %0d want 20", busyFall); end
    checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL basic_done_count got %0d want 1", doneCount); end
  endtask

  task automatic test_wrap();
    int expAddr[4] = '{2046, 2047, 0, 1};
    int expData[4] = '{1, 0, 255, 254};
    int bad = 0;
    doRun(11'd2046, 12'd4, 0, 100);
    checks++; if (timedOut) begin errors++; $display("[TB] FAIL wrap_timeout got done=none want done"); end
    checks++; if (rdAddrs.size() != 4 || beatData.size() != 4) begin
      errors++; $display("[TB] FAIL wrap_count got %0d reads %0d beats want 4 4", rdAddrs.size(), beatData.size());
    end
    for (int i = 0; i < 4 && i < rdAddrs.size() && i < beatData.size(); i++) begin
      if (rdAddrs[i] != expAddr[i] || beatData[i] != expData[i] || beatLast[i] != int'(i == 3)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL wrap_sequence got %0d bad entries want 0", bad); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    int lasts = 0;
    doRun(11'd100, 12'd64, 1, 400);
    checks++; if (timedOut) begin errors++; $display("[TB] FAIL bp_timeout got done=none want done"); end
    checks++; if (beatData.size() != 64) begin errors++; $display("[TB] FAIL bp_count got %0d want 64", beatData.size()); end
    for (int i = 0; i < beatData.size(); i++) begin
      if (beatData[i] != 155 - i) bad++;
      lasts += beatLast[i];
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL bp_order got %0d bad beats want 0", bad); end
    checks++; if (maxOut != 4) begin errors++; $display("[TB] FAIL bp_outstanding got %0d want 4", maxOut); end
    checks++; if (stallBad != 0) begin errors++; $display("[TB] FAIL bp_stall_stable got %0d changes want 0", stallBad); end
    checks++; if (lasts != 1 || beatLast.size() == 0 || beatLast[$] != 1) begin
      errors++; $display("[TB] FAIL bp_last got %0d last flags want 1 on final", lasts);
    end
  endtask

  task automatic test_zero_len();
    doRun(11'd5, 12'd0, 0, 20);
    checks++; if (doneCycle != 1) begin errors++; $display("[TB] FAIL zero_done_cycle got %0d want 1", doneCycle); end
    checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL zero_done_count got %0d want 1", doneCount); end
    checks++; if (issuedCnt != 0) begin errors++; $display("[TB] FAIL zero_reads got %0d want 0", issuedCnt); end
    checks++; if (firstValid >= 0) begin errors++; $display("[TB] FAIL zero_valid got cycle %0d want none", firstValid); end
    checks++; if (busySeen) begin errors++; $display("[TB] FAIL zero_busy got 1 want 0"); end
  endtask

  task automatic test_busy_ignore();
    int bad = 0;
    doRun(11'd300, 12'd8, 2, 100);
    checks++; if (beatData.size() != 8 || rdAddrs.size() != 8) begin
      errors++; $display("[TB] FAIL busy_count got %0d beats %0d reads want 8 8", beatData.size(), rdAddrs.size());
    end
    for (int i = 0; i < beatData.size() && i < rdAddrs.size(); i++) begin
      if (beatData[i] != 211 - i || rdAddrs[i] != 300 + i) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL busy_sequence got %0d bad entries want 0", bad); end
    checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL busy_done_count got %0d want 1", doneCount); end
  endtask

  task automatic test_reset_midrun();
    int seen = 0;
    int spurious = 0;
    bit hit = 0;
    start = 1'b1; startAddr = 11'd0; startLen = 12'd32; mReady = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int c = 1; c <= 40 && !hit; c++) begin
      if (mValid) begin
        seen++;
        if (seen == 5) begin
          hit = 1;
          checks++; if (mData !== 8'd251) begin errors++; $display("[TB] FAIL rst_beat5_data got %0d want 251", mData); end
        end
      end
      if (!hit) stepCycle();
    end
    checks++; if (!hit) begin errors++; $display("[TB] FAIL rst_beat5_reached got %0d beats want 5", seen); end
    rst = 1'b1;
    stepCycle();
    checks++; if (mValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got %b want 0", mValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_done got %b want 0", done); end
    rst = 1'b0;
    repeat (8) begin
      stepCycle();
      if (done || mValid || busy || ramRdEn) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("[TB] FAIL rst_mid_quiet got %0d active cycles want 0", spurious); end
    doRun(11'd0, 12'd2, 0, 40);
    checks++; if (beatData.size() != 2) begin errors++; $display("[TB] FAIL rst_restart_count got %0d want 2", beatData.size()); end
    checks++; if (beatData.size() == 2 && (beatData[0] != 255 || beatData[1] != 254 || beatLast[1] != 1 || beatLast[0] != 0)) begin
      errors++; $display("[TB] FAIL rst_restart_data got %0d,%0d want 255,254", beatData[0], beatData[1]);
    end
    checks++; if (firstValid != 4 || doneCycle != 6) begin
      errors++; $display("[TB] FAIL rst_restart_timing got valid %0d done %0d want 4 6", firstValid, doneCycle);
    end
  endtask

  task automatic test_full_ram();
    int bad = 0;
    int lasts = 0;
    int lastAddr;
    doRun(11'd512, 12'd2048, 0, 2200);
    checks++; if (timedOut) begin errors++; $display("[TB] FAIL full_timeout got done=none want done"); end
    checks++; if (beatData.size() != 2048 || rdAddrs.size() != 2048) begin
      errors++; $display("[TB] FAIL full_count got %0d beats %0d reads want 2048", beatData.size(), rdAddrs.size());
    end
    lastAddr = (rdAddrs.size() == 0) ? -1 : rdAddrs[$];
    checks++; if (lastAddr != 511) begin errors++; $display("[TB] FAIL full_last_addr got %0d want 511", lastAddr); end
    for (int i = 0; i < beatData.size(); i++) begin
      if (beatData[i] != 255 - ((512 + i) % 256)) bad++;
      lasts += beatLast[i];
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL full_data got %0d bad beats want 0", bad); end
    checks++; if (beatData.size() == 0 || beatData[$] != 0) begin errors++; $display("[TB] FAIL full_last_data got nonzero want 0"); end
    checks++; if (lasts != 1 || beatLast.size() == 0 || beatLast[$] != 1) begin
      errors++; $display("[TB] FAIL full_last_flag got %0d flags want 1 on final", lasts);
    end
    checks++; if (doneCycle != 2052) begin errors++; $display("[TB] FAIL full_done_cycle got %0d want 2052", doneCycle); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; startAddr = 11'd0; startLen = 12'd0; mReady = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_busy_ignore();
    test_reset_midrun();
    test_full_ram();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
